// File: rtl/decode_rx_pkg.sv
// Shared types, block-type codes and control characters for the 64b/66b RX decoder.
// Pure declarations: no logic, no latency, no flow control.
package decode_rx_pkg;

    typedef enum logic [2:0] {RX_INIT, RX_C, RX_D, RX_T, RX_E} rx_state_t;
    typedef enum logic [2:0] {BT_C, BT_S, BT_T, BT_D, BT_E} blk_type_t;

    localparam logic [7:0] TYPE_IDLE = 8'h1E;
    localparam logic [7:0] TYPE_OS   = 8'h4B;
    localparam logic [7:0] TYPE_S0   = 8'h78;
    localparam logic [7:0] TYPE_S4   = 8'h33;
    localparam logic [7:0] TYPE_T0   = 8'h87;
    localparam logic [7:0] TYPE_T1   = 8'h99;
    localparam logic [7:0] TYPE_T2   = 8'hAA;
    localparam logic [7:0] TYPE_T3   = 8'hB4;
    localparam logic [7:0] TYPE_T4   = 8'hCC;
    localparam logic [7:0] TYPE_T5   = 8'hD2;
    localparam logic [7:0] TYPE_T6   = 8'hE1;
    localparam logic [7:0] TYPE_T7   = 8'hFF;

    localparam logic [7:0] CH_IDLE  = 8'h07;
    localparam logic [7:0] CH_START = 8'hFB;
    localparam logic [7:0] CH_TERM  = 8'hFD;
    localparam logic [7:0] CH_ERR   = 8'hFE;
    localparam logic [7:0] CH_SEQ   = 8'h9C;

    // Local-fault ordered set, repeated in both 4-byte halves of a lane
    localparam logic [63:0] LF_DAT = 64'h0100009C_0100009C;
    localparam logic [7:0]  LF_CTL = 8'h11;

    function automatic logic [7:0] ctl_code(input logic [6:0] code);
        return (code == 7'd0) ? CH_IDLE : CH_ERR;
    endfunction

    function automatic rx_state_t next_state(input rx_state_t cur, input blk_type_t t);
        rx_state_t nxt;
        nxt = RX_E;
        case (cur)
            RX_D: begin
                if (t == BT_D)      nxt = RX_D;
                else if (t == BT_T) nxt = RX_T;
            end
            RX_E: begin
                if (t == BT_C)      nxt = RX_C;
                else if (t == BT_D) nxt = RX_D;
                else if (t == BT_T) nxt = RX_T;
            end
            default: begin
                if (t == BT_C)      nxt = RX_C;
                else if (t == BT_S) nxt = RX_D;
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/decode_rx_multilane_lane.sv
// Classifies one 66-bit block and produces its decoded bytes and control flags.
// Latency 1 cycle (registered); no backpressure, accepts a block every cycle.
module r_type_decode_lane
    import decode_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [65:0] blk,
    input  logic        bypass,
    output blk_type_t   typ,
    output logic [63:0] dat,
    output logic [7:0]  ctl
);

    logic [1:0]  hdr;
    logic [63:0] p;
    logic [71:0] pp;
    logic [7:0]  t;
    logic [3:0]  tk;
    blk_type_t   typ_d;
    logic [63:0] dat_d;
    logic [7:0]  ctl_d;

    always_comb begin
        hdr   = blk[1:0];
        p     = blk[65:2];
        pp    = {8'h00, p};
        t     = p[7:0];
        typ_d = BT_E;
        dat_d = {8{CH_ERR}};
        ctl_d = 8'hFF;

        // tk = position of the terminate character; 8 means "not a T type"
        case (t)
            TYPE_T0: tk = 4'd0;
            TYPE_T1: tk = 4'd1;
            TYPE_T2: tk = 4'd2;
            TYPE_T3: tk = 4'd3;
            TYPE_T4: tk = 4'd4;
            TYPE_T5: tk = 4'd5;
            TYPE_T6: tk = 4'd6;
            TYPE_T7: tk = 4'd7;
            default: tk = 4'd8;
        endcase

        if (bypass) begin
            typ_d = BT_D;
            dat_d = p;
            ctl_d = 8'h00;
        end else if (hdr == 2'b01) begin
            typ_d = BT_D;
            dat_d = p;
            ctl_d = 8'h00;
        end else if (hdr == 2'b10) begin
            if (t == TYPE_IDLE) begin
                typ_d = BT_C;
                for (int j = 0; j < 8; j++)
                    dat_d[8*j +: 8] = ctl_code(p[8+7*j +: 7]);
                ctl_d = 8'hFF;
            end else if (t == TYPE_OS) begin
                typ_d = BT_C;
                dat_d = {{4{CH_IDLE}}, p[31:8], CH_SEQ};
                ctl_d = 8'hF1;
            end else if (t == TYPE_S0) begin
                typ_d = BT_S;
                dat_d = {p[63:8], CH_START};
                ctl_d = 8'h01;
            end else if (t == TYPE_S4) begin
                typ_d = BT_S;
                for (int j = 0; j < 4; j++)
                    dat_d[8*j +: 8] = ctl_code(p[8+7*j +: 7]);
                dat_d[63:32] = {p[63:40], CH_START};
                ctl_d = 8'h1F;
            end else if (tk != 4'd8) begin
                typ_d = BT_T;
                for (int j = 0; j < 8; j++) begin
                    if (4'(j) < tk)       dat_d[8*j +: 8] = pp[8*j+8 +: 8];
                    else if (4'(j) == tk) dat_d[8*j +: 8] = CH_TERM;
                    else                  dat_d[8*j +: 8] = CH_IDLE;
                end
                ctl_d = 8'hFF << tk[2:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            typ <= BT_E;
            dat <= LF_DAT;
            ctl <= LF_CTL;
        end else begin
            typ <= typ_d;
            dat <= dat_d;
            ctl <= ctl_d;
        end
    end

endmodule

// File: rtl/decode_rx_multilane.sv
// Multi-lane 64b/66b RX decoder: per-lane classify, chained RX FSM, errored-block counter.
// Latency 2 cycles, fully pipelined; no backpressure, a new set of blocks every cycle.
module decode_rx_multilane
    import decode_rx_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int ERRCNT_W = 8
) (
    input  logic                  clk156,
    input  logic                  rstb156,
    input  logic [66*LANES-1:0]   DeScr_RXD,
    input  logic                  blk_lock,
    input  logic                  hi_ber,
    input  logic                  bypass_66decoder,
    input  logic                  clear_errblk,
    output logic [64*LANES-1:0]   rxdata,
    output logic [8*LANES-1:0]    rxcontrol,
    output logic [LANES-1:0]      start_out,
    output logic [LANES-1:0]      terminate_out,
    output logic                  rxlf,
    output logic [ERRCNT_W-1:0]   errd_blks
);

    localparam int INC_W = $clog2(LANES + 1);

    blk_type_t   typ_s1 [LANES];
    logic [63:0] dat_s1 [LANES];
    logic [7:0]  ctl_s1 [LANES];
    logic        force_q;
    logic        byp_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        r_type_decode_lane u_lane (
            .clk    (clk156),
            .rst_n  (rstb156),
            .blk    (DeScr_RXD[66*g +: 66]),
            .bypass (bypass_66decoder),
            .typ    (typ_s1[g]),
            .dat    (dat_s1[g]),
            .ctl    (ctl_s1[g])
        );
    end

    // Link-quality flags travel with the stage-1 data so they act on the same blocks
    always_ff @(posedge clk156 or negedge rstb156) begin
        if (!rstb156) begin
            force_q <= 1'b1;
            byp_q   <= 1'b0;
        end else begin
            force_q <= hi_ber | ~blk_lock;
            byp_q   <= bypass_66decoder;
        end
    end

    rx_state_t              state_q;
    rx_state_t              nxt [LANES];
    logic [INC_W-1:0]       err_inc;
    logic                   any_init;
    logic [ERRCNT_W:0]      err_sum;

    always_comb begin
        rx_state_t prev;
        prev     = state_q;
        err_inc  = '0;
        any_init = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            nxt[i] = force_q ? RX_INIT : next_state(prev, typ_s1[i]);
            prev   = nxt[i];
            if (nxt[i] == RX_E)    err_inc  = err_inc + INC_W'(1);
            if (nxt[i] == RX_INIT) any_init = 1'b1;
        end
        err_sum = {1'b0, errd_blks} + (ERRCNT_W+1)'(err_inc);
    end

    always_ff @(posedge clk156 or negedge rstb156) begin
        if (!rstb156) begin
            state_q       <= RX_INIT;
            rxdata        <= {LANES{LF_DAT}};
            rxcontrol     <= {LANES{LF_CTL}};
            start_out     <= '0;
            terminate_out <= '0;
            rxlf          <= 1'b1;
            errd_blks     <= '0;
        end else begin
            if (!byp_q) begin
                state_q <= nxt[LANES-1];
                rxlf    <= any_init;
            end

            for (int i = 0; i < LANES; i++) begin
                if (byp_q) begin
                    rxdata[64*i +: 64]  <= dat_s1[i];
                    rxcontrol[8*i +: 8] <= 8'h00;
                end else begin
                    case (nxt[i])
                        RX_INIT: begin
                            rxdata[64*i +: 64]  <= LF_DAT;
                            rxcontrol[8*i +: 8] <= LF_CTL;
                        end
                        RX_E: begin
                            rxdata[64*i +: 64]  <= {8{CH_ERR}};
                            rxcontrol[8*i +: 8] <= 8'hFF;
                        end
                        default: begin
                            rxdata[64*i +: 64]  <= dat_s1[i];
                            rxcontrol[8*i +: 8] <= ctl_s1[i];
                        end
                    endcase
                end
                start_out[i]     <= !byp_q && nxt[i] == RX_D && typ_s1[i] == BT_S;
                terminate_out[i] <= !byp_q && nxt[i] == RX_T;
            end

            if (clear_errblk)
                errd_blks <= '0;
            else if (!byp_q && !force_q)
                errd_blks <= err_sum[ERRCNT_W] ? '1 : err_sum[ERRCNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_decode_rx_multilane.sv
// Directed bench for decode_rx_multilane (LANES=2, ERRCNT_W=8).
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_decode_rx_multilane;

    logic         clk156 = 1'b0;
    logic         rstb156;
    logic [131:0] DeScr_RXD;
    logic         blk_lock;
    logic         hi_ber;
    logic         bypass_66decoder;
    logic         clear_errblk;
    logic [127:0] rxdata;
    logic [15:0]  rxcontrol;
    logic [1:0]   start_out;
    logic [1:0]   terminate_out;
    logic         rxlf;
    logic [7:0]   errd_blks;

    int checks = 0;
    int errors = 0;

    decode_rx_multilane #(.LANES(2), .ERRCNT_W(8)) dut (
        .clk156           (clk156),
        .rstb156          (rstb156),
        .DeScr_RXD        (DeScr_RXD),
        .blk_lock         (blk_lock),
        .hi_ber           (hi_ber),
        .bypass_66decoder (bypass_66decoder),
        .clear_errblk     (clear_errblk),
        .rxdata           (rxdata),
        .rxcontrol        (rxcontrol),
        .start_out        (start_out),
        .terminate_out    (terminate_out),
        .rxlf             (rxlf),
        .errd_blks        (errd_blks)
    );

    always #5 clk156 = ~clk156;

    localparam logic [63:0]  LF   = 64'h0100009C_0100009C;
    localparam logic [63:0]  IDL  = 64'h07070707_07070707;
    localparam logic [63:0]  ERR  = 64'hFEFEFEFE_FEFEFEFE;

    function automatic logic [65:0] mk(input logic [1:0] h, input logic [63:0] p);
        return {p, h};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk156);
        #1;
    endtask

    logic [65:0] idle_b;

    initial begin
        idle_b           = mk(2'b10, 64'h1E);
        rstb156          = 1'b0;
        blk_lock         = 1'b0;
        hi_ber           = 1'b0;
        bypass_66decoder = 1'b0;
        clear_errblk     = 1'b0;
        DeScr_RXD        = {idle_b, idle_b};
        #12;
        chk("rst_rxdata", rxdata, {LF, LF});
        chk("rst_rxcontrol", rxcontrol, 16'h1111);
        chk("rst_rxlf", rxlf, 1'b1);
        chk("rst_errd", errd_blks, 8'h00);
        chk("rst_start_term", {start_out, terminate_out}, 4'b0000);

        // Lock achieved, idle stream
        tick(1);
        rstb156  = 1'b1;
        blk_lock = 1'b1;
        tick(2);
        chk("idle_rxdata", rxdata, {IDL, IDL});
        chk("idle_rxcontrol", rxcontrol, 16'hFFFF);
        chk("idle_rxlf", rxlf, 1'b0);

        // S(0x78) + D, then T(0xAA,k=2) + C
        DeScr_RXD = {mk(2'b01, 64'h01234567_89ABCDEF), mk(2'b10, 64'h77665544_33221178)};
        tick(1);
        DeScr_RXD = {idle_b, mk(2'b10, 64'h00000000_0055D5AA)};
        tick(1);
        chk("pkt_s_rxdata", rxdata, {64'h01234567_89ABCDEF, 64'h77665544_332211FB});
        chk("pkt_s_rxcontrol", rxcontrol, 16'h0001);
        chk("pkt_s_start", start_out, 2'b01);
        chk("pkt_s_term", terminate_out, 2'b00);
        DeScr_RXD = {idle_b, idle_b};
        tick(1);
        chk("pkt_t_rxdata", rxdata, {IDL, 64'h07070707_07FD55D5});
        chk("pkt_t_rxcontrol", rxcontrol, 16'hFFFC);
        chk("pkt_t_term", terminate_out, 2'b01);
        chk("pkt_t_start", start_out, 2'b00);
        chk("pkt_errd", errd_blks, 8'h00);

        // D on lane1 right after C on lane0 is illegal
        DeScr_RXD = {mk(2'b01, 64'h11111111_11111111), idle_b};
        tick(1);
        DeScr_RXD = {idle_b, idle_b};
        tick(1);
        chk("cd_rxdata", rxdata, {ERR, IDL});
        chk("cd_rxcontrol", rxcontrol, 16'hFFFF);
        chk("cd_errd", errd_blks, 8'h01);

        // Bad headers on both lanes until the counter saturates
        DeScr_RXD = {mk(2'b00, 64'h0), mk(2'b00, 64'h0)};
        tick(300);
        chk("sat_errd", errd_blks, 8'hFF);
        chk("sat_rxdata", rxdata, {ERR, ERR});
        clear_errblk = 1'b1;
        tick(1);
        chk("clr_errd", errd_blks, 8'h00);
        clear_errblk = 1'b0;
        DeScr_RXD    = {idle_b, idle_b};
        tick(2);
        chk("clr_after_errd", errd_blks, 8'h02);
        chk("clr_after_rxdata", rxdata, {IDL, IDL});

        // hi_ber mid-packet forces LF and suspends counting
        DeScr_RXD = {mk(2'b01, 64'h22222222_22222222), mk(2'b10, 64'h77665544_33221178)};
        tick(1);
        hi_ber    = 1'b1;
        DeScr_RXD = {mk(2'b01, 64'h33333333_33333333), mk(2'b01, 64'h44444444_44444444)};
        tick(2);
        chk("hiber_rxdata", rxdata, {LF, LF});
        chk("hiber_rxcontrol", rxcontrol, 16'h1111);
        chk("hiber_rxlf", rxlf, 1'b1);
        chk("hiber_errd", errd_blks, 8'h02);
        hi_ber    = 1'b0;
        DeScr_RXD = {idle_b, idle_b};
        tick(2);
        chk("recov_rxlf", rxlf, 1'b0);
        chk("recov_rxdata", rxdata, {IDL, IDL});

        // Ordered set 0x4B, then S on lane0 with T(0xFF,k=7) on lane1
        DeScr_RXD = {idle_b, mk(2'b10, 64'h00000000_CCBBAA4B)};
        tick(1);
        DeScr_RXD = {mk(2'b10, 64'h66554433_221100FF), mk(2'b10, 64'hA1A2A3A4_A5A6A778)};
        tick(1);
        chk("os_rxdata", rxdata, {IDL, 64'h07070707_CCBBAA9C});
        chk("os_rxcontrol", rxcontrol, 16'hFFF1);
        DeScr_RXD = {idle_b, idle_b};
        tick(1);
        chk("t7_rxdata", rxdata, {64'hFD665544_33221100, 64'hA1A2A3A4_A5A6A7FB});
        chk("t7_rxcontrol", rxcontrol, 16'h8001);
        chk("t7_flags", {start_out, terminate_out}, 4'b01_10);
        chk("t7_errd", errd_blks, 8'h02);

        // Bypass: raw payload with invalid headers, counter frozen
        bypass_66decoder = 1'b1;
        DeScr_RXD = {mk(2'b00, 64'hDEADBEEF_01234567), mk(2'b11, 64'hDEADBEEF_01234567)};
        tick(2);
        chk("byp_rxdata", rxdata, {64'hDEADBEEF_01234567, 64'hDEADBEEF_01234567});
        chk("byp_rxcontrol", rxcontrol, 16'h0000);
        chk("byp_errd", errd_blks, 8'h02);
        chk("byp_rxlf", rxlf, 1'b0);
        chk("byp_flags", {start_out, terminate_out}, 4'b0000);
        bypass_66decoder = 1'b0;
        DeScr_RXD = {idle_b, idle_b};
        tick(2);
        chk("unbyp_rxdata", rxdata, {IDL, IDL});

        // Asynchronous reset mid-stream
        #2;
        rstb156 = 1'b0;
        #1;
        chk("arst_rxdata", rxdata, {LF, LF});
        chk("arst_rxlf", rxlf, 1'b1);
        chk("arst_errd", errd_blks, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
